// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: prefix scancodes, tracked-key table, decoder states and the event record.
package ps2_pkg;

  localparam logic [7:0] SC_EXT = 8'hE0;
  localparam logic [7:0] SC_BRK = 8'hF0;

  // {ext, code}: ext=1 for E0-prefixed keys
  typedef logic [8:0] key_code_t;

  localparam key_code_t KEY_TABLE [8] = '{
    9'h16B, 9'h172, 9'h175, 9'h174,
    9'h01C, 9'h01B, 9'h01D, 9'h023
  };

  typedef enum logic [1:0] {
    DEC_IDLE    = 2'd0,
    DEC_EXT     = 2'd1,
    DEC_BRK     = 2'd2,
    DEC_EXT_BRK = 2'd3
  } dec_state_t;

  typedef struct packed {
    logic [2:0] slot;
    logic       press;
  } key_event_t;

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: pin synchronisers, 11-bit frame shifter, odd-parity/stop check and
// mid-frame timeout. Emits a one-cycle byte strobe or a one-cycle error pulse per frame.
module ps2_rx #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ps_clk,
  input  logic       ps_data,
  output logic [7:0] rx_byte,
  output logic       rx_strobe,
  output logic       rx_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] data_sync;
  logic                   clk_prev;
  logic                   clk_fall;
  logic                   data_bit;
  logic [3:0]             bit_cnt;
  logic [9:0]             shift;
  logic                   frame_done;
  logic [TW-1:0]          idle_cnt;

  // Lines idle high, so the synchronisers reset to 1 to avoid a false edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync  <= '1;
      data_sync <= '1;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps_data};
      clk_prev  <= clk_sync[SYNC_STAGES-1];
    end
  end

  assign clk_fall = clk_prev & ~clk_sync[SYNC_STAGES-1];
  assign data_bit = data_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt    <= 4'd0;
      shift      <= '0;
      frame_done <= 1'b0;
      idle_cnt   <= '0;
      rx_byte    <= 8'h00;
      rx_strobe  <= 1'b0;
      rx_err     <= 1'b0;
    end else begin
      rx_strobe  <= 1'b0;
      rx_err     <= 1'b0;
      frame_done <= 1'b0;

      // shift holds {stop, parity, data[7:0]} once all ten post-start bits are in
      if (frame_done) begin
        if (shift[9] && (^shift[8:0])) begin
          rx_byte   <= shift[7:0];
          rx_strobe <= 1'b1;
        end else begin
          rx_err <= 1'b1;
        end
      end

      if (clk_fall) begin
        idle_cnt <= '0;
        if (bit_cnt == 4'd0) begin
          if (!data_bit) bit_cnt <= 4'd1;
          else           rx_err  <= 1'b1;
        end else begin
          shift <= {data_bit, shift[9:1]};
          if (bit_cnt == 4'd10) begin
            bit_cnt    <= 4'd0;
            frame_done <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt + 4'd1;
          end
        end
      end else if (bit_cnt != 4'd0) begin
        if (idle_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
          rx_err   <= 1'b1;
          bit_cnt  <= 4'd0;
          idle_cnt <= '0;
        end else begin
          idle_cnt <= idle_cnt + 1'b1;
        end
      end else begin
        idle_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/ps2_key_tracker.sv
// PS/2 keyboard front end: prefix decoder, key-table match, held-key bitmap and event FIFO.
// Optional macro TYPEMATIC_FILTER_EN suppresses press events for keys already held.
module ps2_key_tracker
  import ps2_pkg::*;
#(
  parameter int NUM_KEYS       = 4,
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                Clk,
  input  logic                reset_n,
  input  logic                psClk,
  input  logic                psData,
  output logic [NUM_KEYS-1:0] key_down,
  output logic                ev_valid,
  input  logic                ev_ready,
  output logic [2:0]          ev_slot,
  output logic                ev_press,
  output logic [7:0]          keyCode,
  output logic                press,
  output logic                overflow,
  output logic                frame_err
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [7:0] rx_byte;
  logic       rx_strobe;

  ps2_rx #(
    .SYNC_STAGES    (SYNC_STAGES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_rx (
    .clk       (Clk),
    .reset_n   (reset_n),
    .ps_clk    (psClk),
    .ps_data   (psData),
    .rx_byte   (rx_byte),
    .rx_strobe (rx_strobe),
    .rx_err    (frame_err)
  );

  dec_state_t state, state_next;
  logic       is_make, is_break, code_ext;

  always_comb begin
    state_next = state;
    is_make    = 1'b0;
    is_break   = 1'b0;
    code_ext   = 1'b0;
    if (rx_strobe) begin
      case (state)
        DEC_IDLE: begin
          if (rx_byte == SC_EXT)      state_next = DEC_EXT;
          else if (rx_byte == SC_BRK) state_next = DEC_BRK;
          else                        is_make    = 1'b1;
        end
        DEC_EXT: begin
          if (rx_byte == SC_BRK) begin
            state_next = DEC_EXT_BRK;
          end else if (rx_byte != SC_EXT) begin
            is_make    = 1'b1;
            code_ext   = 1'b1;
            state_next = DEC_IDLE;
          end
        end
        DEC_BRK: begin
          state_next = DEC_IDLE;
          if (rx_byte != SC_EXT && rx_byte != SC_BRK) is_break = 1'b1;
        end
        DEC_EXT_BRK: begin
          // a stray prefix here abandons the sequence rather than guessing
          state_next = DEC_IDLE;
          if (rx_byte != SC_EXT && rx_byte != SC_BRK) begin
            is_break = 1'b1;
            code_ext = 1'b1;
          end
        end
        default: state_next = DEC_IDLE;
      endcase
    end
  end

  key_code_t  lookup;
  logic       hit;
  logic [2:0] match_slot;
  logic       ev_hit;
  logic       push;

  assign lookup = {code_ext, rx_byte};

  // Scan downwards so the lowest matching slot is the one left standing
  always_comb begin
    hit        = 1'b0;
    match_slot = 3'd0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (lookup == KEY_TABLE[i]) begin
        hit        = 1'b1;
        match_slot = 3'(i);
      end
    end
  end

  assign ev_hit = hit & (is_make | is_break);

`ifdef TYPEMATIC_FILTER_EN
  logic [7:0] down_wide;
  assign down_wide = 8'(key_down);
  assign push      = ev_hit & ~(is_make & down_wide[match_slot]);
`else
  assign push      = ev_hit;
`endif

  for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
    always_ff @(posedge Clk or negedge reset_n) begin
      if (!reset_n)                               key_down[gi] <= 1'b0;
      else if (ev_hit && match_slot == 3'(gi))    key_down[gi] <= is_make;
    end
  end

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= DEC_IDLE;
      keyCode <= 8'h00;
      press   <= 1'b0;
    end else begin
      state <= state_next;
      if (rx_strobe) keyCode <= rx_byte;
      if (is_make)       press <= 1'b1;
      else if (is_break) press <= 1'b0;
    end
  end

  // Show-ahead FIFO; pointers carry a wrap bit to tell full from empty
  key_event_t mem [FIFO_DEPTH];
  key_event_t head;
  logic [AW:0] wr_ptr, rd_ptr;
  logic        full, pop, push_ok;

  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign ev_valid = (wr_ptr != rd_ptr);
  assign pop     = ev_valid & ev_ready;
  assign push_ok = push & (~full | pop);

  always_ff @(posedge Clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= '{slot: match_slot, press: is_make};
  end

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok)           wr_ptr   <= wr_ptr + 1'b1;
      if (pop)               rd_ptr   <= rd_ptr + 1'b1;
      if (push && !push_ok)  overflow <= 1'b1;
    end
  end

  assign head     = mem[rd_ptr[AW-1:0]];
  assign ev_slot  = head.slot;
  assign ev_press = head.press;

endmodule
